locked_cla_adder_pipe: RTL and testbench



---
 rtl/locked_cla_pkg.sv | 40 ++++
 rtl/locked_cla_core.sv | 73 +++++++
 rtl/locked_cla_adder_pipe.sv | 164 ++++++++++++++++
 tb/tb_locked_cla_adder_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/locked_cla_pkg.sv
// Shared types and helpers for the key-locked pipelined CLA adder.
package locked_cla_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SHIFT  = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_e;

  typedef enum logic {
    GATE_AND = 1'b0,
    GATE_OR  = 1'b1
  } gate_e;

  localparam int unsigned MAX_KEY_W = 64;

  // Even carry positions are AND-gated, odd positions OR-gated.
  function automatic gate_e gate_type(input int unsigned i);
    return ((i % 2) == 0) ? GATE_AND : GATE_OR;
  endfunction

  // Unlocking key: 1 on AND gates, 0 on OR gates.
  function automatic logic [MAX_KEY_W-1:0] correct_key(input int unsigned key_w);
    logic [MAX_KEY_W-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < MAX_KEY_W; i++) begin
      if (i < key_w) k[i] = (gate_type(i) == GATE_AND);
    end
    return k;
  endfunction

  // Applies key gate i to carry c; positions beyond the key pass through.
  function automatic logic key_gate(input logic c, input logic k,
                                    input int unsigned i, input int unsigned key_w);
    if (i >= key_w) return c;
    return (gate_type(i) == GATE_AND) ? (c & k) : (c | k);
  endfunction

endpackage

// File: rtl/locked_cla_core.sv
// Combinational grouped carry-lookahead adder with a key gate on every carry.
module locked_cla_core
  import locked_cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4,
  parameter int unsigned KEY_W = 16
) (
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_cin,
  input  logic [KEY_W-1:0] i_key,
  output logic [WIDTH:0]   o_sum_c
);

  localparam int unsigned NGRP  = WIDTH / GROUP;
  localparam int unsigned SUM_W = WIDTH + 1;

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_key;
  logic [WIDTH:0]   w_c;
  logic [WIDTH:0]   w_cg;
  logic [NGRP-1:0]  w_grp_g;
  logic [NGRP-1:0]  w_grp_p;
  logic [NGRP-1:0]  w_grp_open;

  assign w_g   = i_add1 & i_add2;
  assign w_p   = i_add1 ^ i_add2;
  assign w_key = SUM_W'(i_key);

  // Group generate/propagate; a group is "open" when no gate sits inside it.
  always_comb begin
    w_grp_g    = '0;
    w_grp_p    = '0;
    w_grp_open = '0;
    for (int unsigned g = 0; g < NGRP; g++) begin
      w_grp_p[g]    = 1'b1;
      w_grp_open[g] = 1'b1;
      for (int unsigned b = 0; b < GROUP; b++) begin
        w_grp_g[g] = w_g[g*GROUP+b] | (w_p[g*GROUP+b] & w_grp_g[g]);
        w_grp_p[g] = w_grp_p[g] & w_p[g*GROUP+b];
        if ((b != 0) && ((g*GROUP+b) < KEY_W)) w_grp_open[g] = 1'b0;
      end
    end
  end

  // Gated carry chain; the gated carry feeds both the sum and the next lookahead.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    w_c   = '0;
    w_cg  = '0;
    w_sum = '0;
    w_c[0] = i_cin;
    for (int unsigned g = 0; g < NGRP; g++) begin
      for (int unsigned b = 0; b < GROUP; b++) begin
        idx          = g*GROUP + b;
        w_cg[idx]    = key_gate(w_c[idx], w_key[idx], idx, KEY_W);
        w_sum[idx]   = w_p[idx] ^ w_cg[idx];
        w_c[idx+1]   = w_g[idx] | (w_p[idx] & w_cg[idx]);
      end
      if (w_grp_open[g]) begin
        w_c[(g+1)*GROUP] = w_grp_g[g] | (w_grp_p[g] & w_cg[g*GROUP]);
      end
    end
    w_cg[WIDTH] = key_gate(w_c[WIDTH], w_key[WIDTH], WIDTH, KEY_W);
  end

  assign o_sum_c = {w_cg[WIDTH], w_sum};

endmodule

// File: rtl/locked_cla_adder_pipe.sv
// Pipelined key-locked CLA adder with serial key load.
// Optional build macro LOCKED_CLA_OUTREG_EN adds a third (output) register stage.
module locked_cla_adder_pipe
  import locked_cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4,
  parameter int unsigned KEY_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic             cin_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH:0]   result_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  input  logic             key_load_i,
  input  logic             key_shift_i,
  input  logic             key_bit_i,
  output logic             key_busy_o
);

  localparam int unsigned CNT_W = $clog2(KEY_W + 1);

  state_e           r_state;
  logic [KEY_W-1:0] r_sr;
  logic [KEY_W-1:0] r_key;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_rst_done;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_cin;
  logic             r_s2_valid;
  logic [WIDTH:0]   r_s2_sum;

  logic [WIDTH:0]   w_sum;
  logic             w_s2_drain;
  logic             w_s1_adv;
  logic             w_accept;
  logic             w_pipe_empty;

`ifdef LOCKED_CLA_OUTREG_EN
  logic             r_s3_valid;
  logic [WIDTH:0]   r_s3_sum;
  logic             w_out_free;

  assign w_out_free   = !r_s3_valid || out_ready_i;
  assign w_s2_drain   = w_out_free;
  assign w_pipe_empty = !r_s1_valid && !r_s2_valid && !r_s3_valid;
  assign result_o     = r_s3_sum;
  assign out_valid_o  = r_s3_valid;

  // Output stage: takes stage 2 whenever it is free or being consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s3_valid <= 1'b0;
      r_s3_sum   <= '0;
    end else if (r_s2_valid && w_out_free) begin
      r_s3_valid <= 1'b1;
      r_s3_sum   <= r_s2_sum;
    end else if (out_ready_i) begin
      r_s3_valid <= 1'b0;
    end
  end
`else
  assign w_s2_drain   = out_ready_i;
  assign w_pipe_empty = !r_s1_valid && !r_s2_valid;
  assign result_o     = r_s2_sum;
  assign out_valid_o  = r_s2_valid;
`endif

  assign w_s1_adv   = r_s1_valid && (!r_s2_valid || w_s2_drain);
  assign in_ready_o = r_rst_done && (r_state == RUN) && (!r_s1_valid || w_s1_adv);
  assign w_accept   = in_valid_i && in_ready_o;
  assign key_busy_o = r_busy;

  locked_cla_core #(
    .WIDTH (WIDTH),
    .GROUP (GROUP),
    .KEY_W (KEY_W)
  ) u_core (
    .i_add1  (r_s1_a),
    .i_add2  (r_s1_b),
    .i_cin   (r_s1_cin),
    .i_key   (r_key),
    .o_sum_c (w_sum)
  );

  // Stage 1: registers accepted operands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_cin   <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= add1_i;
      r_s1_b     <= add2_i;
      r_s1_cin   <= cin_i;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: registers the gated sum using the key active at entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_s2_sum   <= w_sum;
    end else if (w_s2_drain) begin
      r_s2_valid <= 1'b0;
    end
  end

  // Key-load FSM: shift in the key, wait for an empty pipeline, then commit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= RUN;
      r_sr       <= '0;
      r_key      <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      case (r_state)
        RUN: begin
          if (key_load_i) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (key_shift_i) begin
            r_sr  <= KEY_W'({r_sr, key_bit_i});
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(KEY_W - 1)) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_pipe_empty) r_state <= COMMIT;
        end
        COMMIT: begin
          r_key   <= r_sr;
          r_state <= RUN;
          r_busy  <= 1'b0;
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_locked_cla_adder_pipe.sv
// Self-checking bench for locked_cla_adder_pipe (WIDTH=16, GROUP=4, KEY_W=16).
// Honours LOCKED_CLA_OUTREG_EN for the expected latency.
module tb_locked_cla_adder_pipe;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned GROUP = 4;
  localparam int unsigned KEY_W = 16;
`ifdef LOCKED_CLA_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] add1 = '0;
  logic [WIDTH-1:0] add2 = '0;
  logic             cin = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH:0]   result;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             key_load = 1'b0;
  logic             key_shift = 1'b0;
  logic             key_bit = 1'b0;
  logic             key_busy;

  int               n_total = 0;
  int               n_pass = 0;
  int               n_out = 0;
  logic [KEY_W-1:0] m_key = '0;
  logic [WIDTH:0]   exp_q[$];
  logic             hold_v = 1'b0;
  logic [WIDTH:0]   hold_r = '0;

  always #5 clk = ~clk;

  locked_cla_adder_pipe #(.WIDTH(WIDTH), .GROUP(GROUP), .KEY_W(KEY_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .add1_i      (add1),
    .add2_i      (add2),
    .cin_i       (cin),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .result_o    (result),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .key_load_i  (key_load),
    .key_shift_i (key_shift),
    .key_bit_i   (key_bit),
    .key_busy_o  (key_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain arithmetic when unlocked, otherwise bit-serial gated carries.
  function automatic logic [WIDTH:0] model_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic ci, input logic [KEY_W-1:0] k);
    logic           c;
    logic [WIDTH:0] r;
    if (k == 16'h5555) return {1'b0, a} + {1'b0, b} + {16'b0, ci};
    c = ci;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < KEY_W) c = ((i % 2) == 0) ? (c & k[i]) : (c | k[i]);
      r[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    r[WIDTH] = c;
    return r;
  endfunction

  // Scoreboard: record accepted operands, compare every consumed result, check hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(result), 32'(hold_r));
      end
      if (in_valid && in_ready) exp_q.push_back(model_sum(add1, add2, cin, m_key));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_result: got 0x%0h, expected no output", result);
        end else begin
          check("result", 32'(result), 32'(exp_q.pop_front()));
        end
      end
      hold_v = out_valid && !out_ready;
      hold_r = result;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op_direct(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                           input logic [WIDTH:0] exp, input string name);
    int guard;
    int lat;
    out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL %s_ready: got in_ready=0, expected 1 within 50 cycles", name);
      return;
    end
    add1 = a; add2 = b; cin = ci; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (lat < 10) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(LAT));
    check(name, 32'(result), 32'(exp));
    tick();
  endtask

  task automatic load_key(input logic [KEY_W-1:0] k, input bit drain_test);
    int guard;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    check("busy_rise", 32'(key_busy), 32'd1);
    check("load_blocks_input", 32'(in_ready), 32'd0);
    for (int i = KEY_W - 1; i >= 0; i--) begin
      key_shift = 1'b1;
      key_bit = k[i];
      tick();
    end
    key_shift = 1'b0;
    if (drain_test) begin
      // Stray shifts while draining must not alter the pending key.
      for (int i = 0; i < 5; i++) begin
        key_shift = 1'b1;
        key_bit = 1'b1;
        tick();
      end
      key_shift = 1'b0;
      check("drain_busy", 32'(key_busy), 32'd1);
      check("drain_blocks_input", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
    end
    guard = 0;
    while (key_busy && guard < 200) begin
      tick();
      guard++;
    end
    check("busy_fall", 32'(key_busy), 32'd0);
    m_key = k;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int sent;
    int cycles;
    int out0;
    bit acc;

    // Reset values
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_busy", 32'(key_busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Wrong key after reset
    op_direct(16'h0003, 16'h0001, 1'b0, 17'h00000, "lock_3p1");

    // Correct key
    load_key(16'h5555, 1'b0);
    op_direct(16'h0003, 16'h0001, 1'b0, 17'h00004, "unlock_3p1");
    op_direct(16'hFFFF, 16'h0001, 1'b0, 17'h10000, "unlock_ffff");

    // Random back-to-back with random backpressure
    out0 = n_out;
    sent = 0;
    cycles = 0;
    add1 = 16'($urandom); add2 = 16'($urandom); cin = 1'($urandom);
    in_valid = 1'b1;
    while (sent < 100 && cycles < 5000) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      cycles++;
      if (acc) begin
        sent++;
        if (sent < 100) begin
          add1 = 16'($urandom); add2 = 16'($urandom); cin = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 50) begin
      tick();
      cycles++;
    end
    check("random_sent", 32'(sent), 32'd100);
    check("random_count", 32'(n_out - out0), 32'd100);
    check("random_queue_empty", 32'(exp_q.size()), 32'd0);

    // Key load with operations in flight: they finish with the old key
    out_ready = 1'b0;
    add1 = 16'h00FF; add2 = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    tick();
    add1 = 16'hFFFF; add2 = 16'hFFFF; cin = 1'b1;
    tick();
    in_valid = 1'b0;
    load_key(16'h0000, 1'b1);
    check("inflight_drained", 32'(exp_q.size()), 32'd0);
    op_direct(16'h0003, 16'h0001, 1'b0, 17'h00000, "relock_3p1");
    op_direct(16'hFFFF, 16'h0001, 1'b0, 17'h0FFFC, "relock_ffff");

    // Reset in the middle of a key load
    load_key(16'h5555, 1'b0);
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      key_shift = 1'b1;
      key_bit = ((i % 2) == 1);
      tick();
    end
    key_shift = 1'b0;
    rst_n = 1'b0;
    #2;
    check("midload_rst_busy", 32'(key_busy), 32'd0);
    check("midload_rst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    m_key = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    op_direct(16'h0003, 16'h0001, 1'b0, 17'h00000, "midload_rst_3p1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
